// File: rtl/burst_write_resp_collector_if.sv
// rtl/burst_write_resp_collector_if.sv - command, beat-response and completion signals of the response collector
// Ports (signals):
//   c_addr/c_length/c_valid -> c_ready    : burst command from the requester side
//   r_data/r_valid          -> r_ready    : per-beat write response from the burst pipeline
//   b_addr/b_len/b_resp/b_valid <- b_ready: aggregated burst completion
//   outstanding                           : commands currently queued
// master modport drives commands, beats and b_ready; slave modport is the collector.
interface burst_write_resp_collector_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 3
);
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [7:0]            c_length;
    logic                  c_valid;
    logic                  c_ready;
    logic [ADDR_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [7:0]            b_len;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;
    logic [CNT_WIDTH-1:0]  outstanding;

    modport master (
        output c_addr, c_length, c_valid, r_data, r_valid, b_ready,
        input  c_ready, r_ready, b_addr, b_len, b_resp, b_valid, outstanding
    );

    modport slave (
        input  c_addr, c_length, c_valid, r_data, r_valid, b_ready,
        output c_ready, r_ready, b_addr, b_len, b_resp, b_valid, outstanding
    );
endinterface

// File: rtl/burst_write_resp_collector.sv
// rtl/burst_write_resp_collector.sv - collects per-beat write responses into one completion per burst
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave modport; c_* commands into the FIFO, r_* beat responses,
//            b_* completion (addr, len-1, OKAY/SLVERR), outstanding = queued commands
module burst_write_resp_collector #(
    parameter int ADDR_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    burst_write_resp_collector_if.slave  bus
);
    localparam int PTR_WIDTH = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(CMD_DEPTH);

    logic [ADDR_WIDTH-1:0] r_fifo_addr [CMD_DEPTH];
    logic [7:0]            r_fifo_len  [CMD_DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [7:0]            r_beat_cnt;
    logic                  r_err_acc;
    logic [ADDR_WIDTH-1:0] r_b_addr;
    logic [7:0]            r_b_len;
    logic [1:0]            r_b_resp;
    logic                  r_b_valid;

    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [7:0]            w_head_len;
    logic [ADDR_WIDTH-1:0] w_exp_addr;
    logic                  w_c_ready;
    logic                  w_r_ready;
    logic                  w_push;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_mismatch;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_len  = r_fifo_len[r_rd_ptr];
    assign w_exp_addr  = w_head_addr + ADDR_WIDTH'(r_beat_cnt);

    // Full check uses only the registered count so c_ready never depends on a same-cycle pop.
    assign w_c_ready = (r_count != FULL_CNT);
    // A beat may only be taken when the completion register is free or being drained,
    // because the last beat of a burst reloads it.
    assign w_r_ready = (r_count != '0) && (!r_b_valid || bus.b_ready);

    assign w_push = bus.c_valid && w_c_ready;
    assign w_beat = bus.r_valid && w_r_ready;
    assign w_last = w_beat && (r_beat_cnt == w_head_len);
    // Anything other than a definite match (including X/Z response data) is an error.
    assign w_mismatch = !((bus.r_data == w_exp_addr) === 1'b1);

    assign bus.c_ready     = w_c_ready;
    assign bus.r_ready     = w_r_ready;
    assign bus.b_addr      = r_b_addr;
    assign bus.b_len       = r_b_len;
    assign bus.b_resp      = r_b_resp;
    assign bus.b_valid     = r_b_valid;
    assign bus.outstanding = r_count;

    // Command storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.c_addr;
            r_fifo_len[r_wr_ptr]  <= bus.c_length;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            r_err_acc  <= 1'b0;
            r_b_addr   <= '0;
            r_b_len    <= '0;
            r_b_resp   <= 2'b00;
            r_b_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_last) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end

            if (w_push && !w_last) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (!w_push && w_last) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end

            if (w_beat) begin
                if (w_last) begin
                    r_beat_cnt <= '0;
                    r_err_acc  <= 1'b0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                    r_err_acc  <= r_err_acc | w_mismatch;
                end
            end

            // A last beat during a draining handshake reloads the register, keeping b_valid high.
            if (w_last) begin
                r_b_addr  <= w_head_addr;
                r_b_len   <= w_head_len;
                r_b_resp  <= (r_err_acc || w_mismatch) ? 2'b10 : 2'b00;
                r_b_valid <= 1'b1;
            end else if (r_b_valid && bus.b_ready) begin
                r_b_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_burst_write_resp_collector.sv
// tb/tb_burst_write_resp_collector.sv - scoreboard bench for burst_write_resp_collector
module tb_burst_write_resp_collector;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [1:0]    resp;
    } cpl_t;

    typedef struct packed {
        logic [AW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    burst_write_resp_collector_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    burst_write_resp_collector #(
        .ADDR_WIDTH(AW),
        .CMD_DEPTH (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    cpl_t  cmd_q[$];
    beat_t beat_q[$];
    cpl_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int m_count = 0;
    bit m_bvalid = 1'b0;
    bit drv_en = 1'b0;
    int cmd_rate = 100;
    int beat_rate = 100;
    int bready_rate = 100;
    int bv_run = 0;
    int bv_max = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a burst's beats are its start address plus beat index (wrapping),
    // and the completion is SLVERR iff any beat was corrupted.
    function automatic void plan_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                                       input int bad_idx, input logic [AW-1:0] bad_data);
        cpl_t  c;
        beat_t b;
        c.addr = addr;
        c.len  = len;
        c.resp = 2'b00;
        for (int i = 0; i <= int'(len); i++) begin
            b.data = addr + AW'(i);
            b.last = (i == int'(len));
            if (i == bad_idx && bad_data != b.data) begin
                b.data = bad_data;
                c.resp = 2'b10;
            end
            beat_q.push_back(b);
        end
        cmd_q.push_back(c);
        exp_q.push_back(c);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_b_valid"}, bus.b_valid, 0);
        check({tag, "_b_addr"}, bus.b_addr, 0);
        check({tag, "_b_len"}, bus.b_len, 0);
        check({tag, "_b_resp"}, bus.b_resp, 0);
        check({tag, "_outstanding"}, bus.outstanding, 0);
        check({tag, "_c_ready"}, bus.c_ready, 1);
        check({tag, "_r_ready"}, bus.r_ready, 0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || beat_q.size() != 0 || cmd_q.size() != 0 || m_bvalid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, (n >= budget), 0);
    endtask

    // Driver: inputs change 1 time unit after the rising edge.
    initial begin
        bus.c_valid  = 1'b0;
        bus.c_addr   = '0;
        bus.c_length = '0;
        bus.r_valid  = 1'b0;
        bus.r_data   = '0;
        bus.b_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (drv_en && cmd_q.size() != 0 && $urandom_range(99) < cmd_rate) begin
                bus.c_valid  = 1'b1;
                bus.c_addr   = cmd_q[0].addr;
                bus.c_length = cmd_q[0].len;
            end else begin
                bus.c_valid  = 1'b0;
                bus.c_addr   = $urandom;
                bus.c_length = 8'($urandom);
            end
            if (drv_en && beat_q.size() != 0 && $urandom_range(99) < beat_rate) begin
                bus.r_valid = 1'b1;
                bus.r_data  = beat_q[0].data;
            end else begin
                bus.r_valid = 1'b0;
                bus.r_data  = $urandom;
            end
            bus.b_ready = drv_en && ($urandom_range(99) < bready_rate);
        end
    end

    // Monitor/scoreboard: samples on the falling edge, when inputs for the next rising edge are stable.
    always @(negedge clk) begin
        bit   m_rready;
        bit   cmd_fire;
        bit   beat_fire;
        bit   last_fire;
        beat_t b;
        if (rst_n) begin
            m_rready = (m_count != 0) && (!m_bvalid || bus.b_ready);
            check("outstanding", bus.outstanding, m_count);
            check("c_ready", bus.c_ready, (m_count != DEPTH));
            check("r_ready", bus.r_ready, m_rready);
            check("b_valid", bus.b_valid, m_bvalid);
            if (m_bvalid) begin
                if (exp_q.size() == 0) begin
                    check("completion_expected", 1, 0);
                end else begin
                    check("b_addr", bus.b_addr, exp_q[0].addr);
                    check("b_len", bus.b_len, exp_q[0].len);
                    check("b_resp", bus.b_resp, exp_q[0].resp);
                end
            end
            bv_run = bus.b_valid ? bv_run + 1 : 0;
            if (bv_run > bv_max) bv_max = bv_run;

            cmd_fire  = bus.c_valid && (m_count != DEPTH);
            beat_fire = bus.r_valid && m_rready && (beat_q.size() != 0);
            last_fire = 1'b0;
            if (m_bvalid && bus.b_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (cmd_fire && cmd_q.size() != 0) begin
                void'(cmd_q.pop_front());
                m_count++;
            end
            if (beat_fire) begin
                b = beat_q.pop_front();
                if (b.last) begin
                    last_fire = 1'b1;
                    m_count--;
                end
            end
            if (last_fire) m_bvalid = 1'b1;
            else if (m_bvalid && bus.b_ready) m_bvalid = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        int n;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        drv_en = 1'b1;

        // single burst
        plan_burst(32'h10, 8'd3, -1, '0);
        wait_idle(100, "single");

        // sticky error, then cleared for the next burst
        plan_burst(32'h20, 8'd2, 1, 32'hDEAD);
        plan_burst(32'h30, 8'd0, -1, '0);
        wait_idle(100, "sticky");

        // FIFO full, then completion backpressure
        beat_rate = 0;
        for (int i = 0; i < 5; i++) plan_burst(32'h100 + 32'(i * 16), 8'd1, -1, '0);
        repeat (8) @(posedge clk);
        #3;
        check("fifth_held", cmd_q.size(), 1);
        check("full_outstanding", bus.outstanding, DEPTH);
        check("full_c_ready", bus.c_ready, 0);
        bready_rate = 0;
        beat_rate = 100;
        n = 0;
        while (!m_bvalid && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("bp_completion_seen", m_bvalid, 1);
        @(posedge clk);
        #3;
        sz = beat_q.size();
        repeat (5) @(posedge clk);
        #3;
        check("beats_stalled", beat_q.size(), sz);
        check("bp_r_ready", bus.r_ready, 0);
        check("fifth_pushed", cmd_q.size(), 0);
        bready_rate = 100;
        wait_idle(200, "backpressure");

        // back-to-back len-0 completions
        bv_max = 0;
        plan_burst(32'h40, 8'd0, -1, '0);
        plan_burst(32'h41, 8'd0, -1, '0);
        plan_burst(32'h42, 8'd0, -1, '0);
        wait_idle(100, "b2b");
        check("b2b_run", (bv_max >= 3), 1);

        // address wrap
        plan_burst(32'hFFFF_FFFF, 8'd1, -1, '0);
        wait_idle(100, "wrap");

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            plan_burst($urandom, 8'($urandom_range(7)),
                       ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1, $urandom);
        end
        for (int i = 0; i < 6; i++) begin
            cmd_rate    = 30 + $urandom_range(70);
            beat_rate   = 30 + $urandom_range(70);
            bready_rate = 30 + $urandom_range(70);
            repeat (60) @(posedge clk);
        end
        cmd_rate = 100;
        beat_rate = 100;
        bready_rate = 100;
        wait_idle(2000, "random");

        // reset in the middle of a burst
        plan_burst(32'h50, 8'd3, -1, '0);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (beat_q.size() > 2 && n < 30);
        check("midburst_two_beats", beat_q.size(), 2);
        drv_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        cmd_q.delete();
        beat_q.delete();
        exp_q.delete();
        m_count = 0;
        m_bvalid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        drv_en = 1'b1;
        bv_max = 0;
        repeat (10) @(posedge clk);
        check("no_completion_after_reset", bv_max, 0);
        plan_burst(32'h60, 8'd2, -1, '0);
        wait_idle(100, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/burst_write_resp_collector.md
Name: burst_write_resp_collector

Overview:
- Sits directly downstream of the burst write pipeline and consumes its per-beat write responses.
- Records each burst command accepted by the pipeline (start address, length-1) in a command FIFO.
- Checks every beat response against the expected beat address.
- Emits one aggregated completion per burst: start address, length and OKAY/SLVERR status, for the requester.

Parameters:
ADDR_WIDTH, 32, address and beat-response width in bits
CMD_DEPTH, 4, command FIFO depth (outstanding bursts); power of 2, >= 2
CNT_WIDTH, 3, width of outstanding count = log2(CMD_DEPTH)+1

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
c_addr  input  ADDR_WIDTH  burst start address (copy of address issued to pipeline)
c_length  input  8  burst length minus 1
c_valid  input  1  command valid
c_ready  output  1  command FIFO can accept
r_data  input  ADDR_WIDTH  per-beat response (pipeline returns the beat address on success)
r_valid  input  1  beat response valid
r_ready  output  1  beat response accepted
b_addr  output  ADDR_WIDTH  completed burst start address
b_len  output  8  completed burst length minus 1
b_resp  output  2  2'b00 OKAY, 2'b10 SLVERR
b_valid  output  1  completion valid
b_ready  input  1  completion consumer ready
outstanding  output  CNT_WIDTH  number of commands in FIFO

Behaviour:
- Reset (async, rst_n low): FIFO pointers and count = 0; beat_cnt = 0; err_acc = 0; b_valid = 0; b_addr = 0; b_len = 0; b_resp = 2'b00; outstanding = 0; c_ready = 1; r_ready = 0. Reset mid-burst discards all queued commands and partial state; no completion is emitted for them.
- Command FIFO:
  - Push on c_valid && c_ready.
  - c_ready = (count != CMD_DEPTH); it depends only on registered count, never on the same-cycle pop.
  - Push and pop in the same cycle: count unchanged, both occur.
  - Pointers wrap modulo CMD_DEPTH.
  - outstanding = count, registered.
- Beat acceptance: r_ready = (count != 0) && (!b_valid || b_ready), combinational. Beat accepted on r_valid && r_ready.
- Head command: H_addr, H_len.
  - Expected beat address = (H_addr + beat_cnt) mod 2^ADDR_WIDTH.
  - beat_cnt is 8-bit, 0..H_len.
- Per accepted beat:
  - mismatch when (r_data == expected) is not true. An X/Z r_data therefore counts as a mismatch.
  - Not last (beat_cnt != H_len): beat_cnt++; err_acc |= mismatch.
  - Last (beat_cnt == H_len):
    - b_addr <= H_addr; b_len <= H_len.
    - b_resp <= (err_acc | mismatch) ? 2'b10 : 2'b00.
    - b_valid <= 1; pop FIFO; beat_cnt <= 0; err_acc <= 0.
- Latency: b_valid rises the cycle after the last beat is accepted. For H_len = 0, the single beat is both first and last.
- Completion handshake:
  - b_valid drops on b_valid && b_ready unless a new last beat is accepted in the same cycle; in that case the register reloads and b_valid stays 1. Back-to-back completions are allowed.
  - b_* outputs remain stable while b_valid && !b_ready.
- Beats with an empty FIFO are never accepted (r_ready = 0); r_valid may stay high.
- A command pushed into an empty FIFO becomes head the next cycle. A beat on that cycle is not accepted.
- Address wrap: H_addr = 2^ADDR_WIDTH-1 with H_len = 1 expects beats max, then 0.

Test Plan:
- Single burst: push (addr 0x10, len 3); beats 0x10,0x11,0x12,0x13 back-to-back, b_ready=1 -> one completion 1 cycle after beat 3: b_addr=0x10, b_len=3, b_resp=00; outstanding 1->0.
- Error sticky: push (0x20, len 2); beats 0x20, 0xDEAD, 0x22 -> b_resp=10, b_addr=0x20; next burst (0x30, len 0) beat 0x30 -> b_resp=00 (err_acc cleared).
- FIFO full/backpressure: push 5 commands with CMD_DEPTH=4 and no beats -> c_ready=0 after 4th, outstanding=4, 5th held until the first burst's last beat pops. Then hold b_ready=0 with b_valid=1 -> r_ready=0, next beats stall, b_* stable; release -> beats resume.
- Back-to-back: three len-0 bursts (0x40,0x41,0x42), r_valid continuous, b_ready=1 -> b_valid high 3 consecutive cycles with addrs 0x40,0x41,0x42, all OKAY.
- Wrap and reset: push (0xFFFFFFFF, len 1), beats 0xFFFFFFFF, 0x00000000 -> OKAY. Then push (0x50, len 3), accept 2 beats, assert rst_n low mid-cycle -> all outputs at reset values immediately, outstanding=0, no completion after release.
